// File: rtl/regfile_wb.sv
// Register file + writeback stage; optional read bypass of the pending write under REGFILE_BYPASS_EN.
// Latency: accepted writeback commits to the array and pulses commit_valid one cycle after acceptance.
// Backpressure: wb_ready low only during the post-reset CLEAR sweep; in RUN every writeback is accepted.
module regfile_wb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            commit_valid,
  output logic [AW-1:0]   commit_rd,
  output logic [XLEN-1:0] commit_data,
  output logic [31:0]     retire_cnt
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NUM_REGS];
  logic            pend_v;
  logic [AW-1:0]   pend_rd;
  logic [XLEN-1:0] pend_data;
  logic [31:0]     retire_q;
  logic            xfer;

  assign wb_ready   = (state == RUN);
  assign xfer       = wb_valid && wb_ready;
  assign retire_cnt = retire_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      pend_v       <= 1'b0;
      pend_rd      <= '0;
      pend_data    <= '0;
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
      retire_q     <= '0;
    end else begin
      if (state == CLEAR) begin
        if (clr_idx == LAST_IDX) begin
          state <= RUN;
        end else begin
          clr_idx <= clr_idx + 1'b1;
        end
      end
      // Pending slot reloads every edge, so it never blocks the next transfer.
      pend_v <= xfer;
      if (xfer) begin
        pend_rd   <= wb_rd;
        pend_data <= wb_data;
      end
      commit_valid <= pend_v;
      if (pend_v) begin
        commit_rd   <= pend_rd;
        commit_data <= pend_data;
        retire_q    <= retire_q + 32'd1;
      end
    end
  end

  // Array is not reset; the CLEAR sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (pend_v && (pend_rd != '0) && (int'(pend_rd) < NUM_REGS)) begin
      mem[pend_rd] <= pend_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if ((state == RUN) && (rs1_addr != '0) && (int'(rs1_addr) < NUM_REGS)) begin
`ifdef REGFILE_BYPASS_EN
      if (pend_v && (rs1_addr == pend_rd)) begin
        rs1_data = pend_data;
      end else begin
        rs1_data = mem[rs1_addr];
      end
`else
      rs1_data = mem[rs1_addr];
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if ((state == RUN) && (rs2_addr != '0) && (int'(rs2_addr) < NUM_REGS)) begin
`ifdef REGFILE_BYPASS_EN
      if (pend_v && (rs2_addr == pend_rd)) begin
        rs2_data = pend_data;
      end else begin
        rs2_data = mem[rs2_addr];
      end
`else
      rs2_data = mem[rs2_addr];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Randomized bench for regfile_wb against a transaction-level register model.
module tb_regfile_wb;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   rs1_addr = '0;
  logic [AW-1:0]   rs2_addr = '0;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_valid = 1'b0;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            commit_valid;
  logic [AW-1:0]   commit_rd;
  logic [XLEN-1:0] commit_data;
  logic [31:0]     retire_cnt;

  regfile_wb #(.XLEN(XLEN), .NUM_REGS(NR), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents plus the write accepted last cycle.
  logic [31:0] m_mem [NR];
  int          m_edges;
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [31:0] m_pdat;
  logic        m_cv;
  logic [4:0]  m_crd;
  logic [31:0] m_cdat;
  logic [31:0] m_cnt;

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
    if (m_edges < NR || a == '0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (m_pv && m_prd == a) return m_pdat;
`endif
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_mem[i] = 32'd0;
    m_edges = 0; m_pv = 1'b0; m_prd = '0; m_pdat = '0;
    m_cv = 1'b0; m_crd = '0; m_cdat = '0; m_cnt = '0;
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] rd, input logic [31:0] d,
                     input logic [AW-1:0] a1, input logic [AW-1:0] a2, output logic rdy_obs);
    logic acc;
    wb_valid = v; wb_rd = rd; wb_data = d; rs1_addr = a1; rs2_addr = a2;
    #1;
    rdy_obs = wb_ready;
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, m_edges >= NR});
    chk("rs1_data", rs1_data, exp_read(a1));
    chk("rs2_data", rs2_data, exp_read(a2));
    chk("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
    if (m_cv) begin
      chk("commit_rd", {27'd0, commit_rd}, {27'd0, m_crd});
      chk("commit_data", commit_data, m_cdat);
    end
    chk("retire_cnt", retire_cnt, m_cnt);
    acc = v && (m_edges >= NR);
    @(posedge clk);
    #1;
    m_cv = m_pv;
    if (m_pv) begin
      m_crd = m_prd; m_cdat = m_pdat; m_cnt = m_cnt + 32'd1;
      if (m_prd != 0) m_mem[m_prd] = m_pdat;
    end
    m_pv = acc;
    if (acc) begin m_prd = rd; m_pdat = d; end
    m_edges++;
  endtask

  task automatic do_reset();
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    rst_n = 1'b0;
    #1;
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_commit_rd", {27'd0, commit_rd}, 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    chk("rst_rs1_data", rs1_data, 32'd0);
    chk("rst_rs2_data", rs2_data, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int   nz;
    logic [AW-1:0] rr;
    model_reset();
    #2 do_reset();

    // CLEAR sweep: valid held high, count cycles with wb_ready low.
    nz = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 5'd0, 32'd0, AW'($urandom), AW'($urandom), r);
      if (r) break;
      nz++;
    end
    chk("clear_cycles", nz, NR);

    for (int i = 1; i < NR; i++) cyc(1'b0, 5'd0, 32'd0, AW'(i), AW'(NR - i), r);

    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, r);
    #1 chk("rd5_value", rs1_data, 32'hDEADBEEF);

    cyc(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, r);
    #1 chk("rd0_value", rs2_data, 32'd0);

    cyc(1'b1, 5'd7, 32'h1, 5'd7, 5'd7, r);
    cyc(1'b1, 5'd7, 32'h2, 5'd7, 5'd7, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, r);
    #1 chk("rd7_last_wins", rs1_data, 32'h2);

    dut.retire_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cyc(1'b1, 5'd3, 32'h0000_0333, 5'd3, 5'd0, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, r);
    cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, r);
    #1 chk("retire_wrap", retire_cnt, 32'd0);

    for (int i = 0; i < 400; i++) begin
      rr = AW'($urandom_range(0, 7));
      cyc(($urandom % 4) != 0, rr, $urandom,
          (($urandom % 2) != 0) ? rr : AW'($urandom_range(0, 7)), AW'($urandom), r);
    end

    cyc(1'b1, 5'd9, 32'hCAFE0009, 5'd9, 5'd9, r);
    #2 do_reset();
    for (int i = 0; i < NR + 2; i++) cyc(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, r);
    #1 chk("rd9_after_reset", rs1_data, 32'd0);
    chk("retire_after_reset", retire_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
